pulse_period_meter: RTL
=======================

// Module: pulse_period_meter
// PURPOSE
// - Measures the clk-cycle interval between consecutive rising edges of a strobe (e.g. hsync/vsync).
// - Measurement-side counterpart to the periodic timer pulse generator: that block makes a pulse every N cycles;
//   this block recovers N from a pulse train.
// - Results go out on a valid/ready interface to the video-timing checker/config logic.
// - A missing pulse is flagged by a timeout.
// PARAMETERS
// - CNT_W    16     width of the period counter and of period_out
// - MAX      65535  timeout threshold in cycles (must be < 2**CNT_W)
// - LOCK_CNT 4      consecutive equal periods needed for lock (only with PERIOD_LOCK_EN)
// PORTS
// - clk           in   1      system clock; all logic on posedge
// - rst           in   1      synchronous reset, active-high
// - meas_ena      in   1      1 = measure; 0 = return to IDLE
// - pulse_in      in   1      strobe, already synchronous to clk
// - period_out    out  CNT_W  measured period in cycles
// - period_valid  out  1      period_out holds an unaccepted result
// - period_ready  in   1      consumer accepts result when valid&ready
// - timeout       out  1      1-cycle pulse: no edge within MAX cycles
// - overrun       out  1      sticky: a result was dropped (consumer too slow)
// - busy          out  1      state != IDLE
// - locked        out  1      period stable (tied 0 without PERIOD_LOCK_EN)
// BEHAVIOUR
// - Reset values:
//   - state=IDLE, cnt=0, period_out=0.
//   - period_valid=0, timeout=0, overrun=0, locked=0.
//   - pulse_d=1, so a pulse_in already high at reset release is not treated as an edge.
// - Edge detect: rise = pulse_in & ~pulse_d; pulse_d <= pulse_in every cycle.
// - States:
//   - IDLE: cnt=0. If meas_ena=1, go to ARM next cycle.
//   - ARM: wait for the first rise. On rise, go to MEAS with cnt<=1.
//   - MEAS: cnt<=cnt+1 each cycle.
//     - On rise: capture cnt, set cnt<=1, stay in MEAS.
//     - Edges at t0 and t1 give a captured value of t1-t0. Minimum legal period is 2.
//     - Timeout: cnt==MAX with no rise in that cycle: timeout=1 for 1 cycle, go to ARM, cnt<=0, nothing captured.
//     - Rise in the same cycle as cnt==MAX: capture MAX, no timeout.
// - meas_ena=0 from any state:
//   - Go to IDLE next cycle, cnt<=0; clears overrun and locked.
//   - A pending result stays valid until accepted.
// - Capture latency: period_out/period_valid update the cycle after the rise.
// - Output handshake:
//   - period_out is stable while period_valid=1. A transfer happens on valid&ready.
//   - Capture while valid&~ready: new value dropped, old one kept, overrun<=1.
//   - Capture while valid&ready: load new value, valid stays 1.
//   - Accept with no capture: valid<=0.
// - Reset mid-measurement: takes priority over everything and applies the reset values next cycle.
// - The counter never wraps, because the MAX timeout fires first.
// CONFIGURATION
// - PERIOD_LOCK_EN defined:
//   - Keep last captured period and a match counter (width >= clog2(LOCK_CNT+1)).
//   - Capture equal to the last: match count +1, saturating at LOCK_CNT. Unequal: reset count to 1.
//   - locked=1 while count==LOCK_CNT.
//   - timeout, or leaving MEAS: locked=0 and count=0.
//   - Dropped (overrun) captures still update lock tracking.
// - PERIOD_LOCK_EN undefined: lock logic absent, locked tied to 0.
// TESTING
// - Edges every 100 cycles, period_ready=1: period_out=100 with valid one cycle after each edge after the first.
//   timeout=0 throughout.
// - MAX=200, one edge then none: timeout pulses once 200 cycles after the edge and busy stays 1 (ARM).
//   Next two edges 50 apart -> period_out=50.
// - period_ready=0 with edges every 20 cycles: first result held stable, overrun=1 after the second capture.
//   Raising ready gives the first value; meas_ena=0 clears overrun.
// - pulse_in held high across rst release: no capture and no state change until a low->high.
// - rst=1 mid-MEAS (cnt=37): next cycle all outputs at reset values, state IDLE.
// - PERIOD_LOCK_EN, LOCK_CNT=4:
//   - Periods 64,64,64,64 -> locked=1 after the 4th capture.
//   - Then 65 -> locked=0 the cycle after that capture.

Source files
------------

// File: rtl/pulse_period_meter_if.sv
// Result handshake from pulse_period_meter to its consumer (video-timing checker/config).
interface pulse_period_meter_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             period_ready;

    modport master (output period_out, output period_valid, input period_ready);
    modport slave  (input period_out, input period_valid, output period_ready);
endinterface

// File: rtl/pulse_period_meter.sv
// Recovers the clk-cycle period of a synchronous strobe and flags missing pulses.
// Optional period-lock tracking is compiled in with `define PERIOD_LOCK_EN.
module pulse_period_meter #(
    parameter int CNT_W    = 16,
    parameter int MAX      = 65535,
    parameter int LOCK_CNT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 meas_ena,
    input  logic                 pulse_in,
    pulse_period_meter_if.master res,
    output logic                 timeout,
    output logic                 overrun,
    output logic                 busy,
    output logic                 locked
);

    if (MAX < 2 || MAX >= (2 ** CNT_W) || LOCK_CNT < 1) begin : g_param_check
        $error("pulse_period_meter: MAX must be in [2, 2**CNT_W) and LOCK_CNT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pulse_d;
    logic             rise;
    logic             capture;
    logic             timeout_nxt;
    logic             drop;

    assign rise = pulse_in & ~pulse_d;
    assign busy = (state != IDLE);
    // A capture is lost only when the held result is still unaccepted this cycle.
    assign drop = capture & res.period_valid & ~res.period_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        capture     = 1'b0;
        timeout_nxt = 1'b0;
        if (!meas_ena) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt   = '0;
                    state_nxt = ARM;
                end
                ARM: begin
                    if (rise) begin
                        state_nxt = MEAS;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                MEAS: begin
                    if (rise) begin
                        capture = 1'b1;
                        cnt_nxt = CNT_W'(1);
                    end else if (cnt == CNT_W'(MAX)) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = ARM;
                        cnt_nxt     = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt              <= '0;
            pulse_d          <= 1'b1;
            timeout          <= 1'b0;
            overrun          <= 1'b0;
            res.period_out   <= '0;
            res.period_valid <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            pulse_d <= pulse_in;
            timeout <= timeout_nxt;
            if (capture && !drop) begin
                res.period_out   <= cnt;
                res.period_valid <= 1'b1;
            end else if (res.period_valid && res.period_ready) begin
                res.period_valid <= 1'b0;
            end
            if (!meas_ena) begin
                overrun <= 1'b0;
            end else if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef PERIOD_LOCK_EN
    localparam int LOCK_W = $clog2(LOCK_CNT + 1);

    logic [CNT_W-1:0]  last_period;
    logic [LOCK_W-1:0] match_cnt;

    function automatic logic [LOCK_W-1:0] sat_inc(input logic [LOCK_W-1:0] v);
        return (v == LOCK_W'(LOCK_CNT)) ? v : v + LOCK_W'(1);
    endfunction

    // Dropped captures still count: lock reflects the pulse train, not the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_period <= '0;
            match_cnt   <= '0;
        end else if (capture) begin
            last_period <= cnt;
            match_cnt   <= (cnt == last_period) ? sat_inc(match_cnt) : LOCK_W'(1);
        end else if (state_nxt != MEAS) begin
            match_cnt <= '0;
        end
    end

    assign locked = (match_cnt == LOCK_W'(LOCK_CNT));
`else
    assign locked = 1'b0;
`endif

endmodule
